// File: rtl/adder_share_ctrl.sv
// Arbitrates two 24-bit add requesters onto one shared 12-bit adder,
// computing each sum as a low half, a high half and an optional carry increment.
module adder_share_ctrl #(
  parameter bit RR_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  input  logic        req1_valid,
  output logic        req0_ready,
  output logic        req1_ready,
  input  logic [23:0] req0_a,
  input  logic [23:0] req0_b,
  input  logic [23:0] req1_a,
  input  logic [23:0] req1_b,
  output logic [23:0] add_in,
  input  logic [12:0] add_out,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [24:0] rsp_sum,
  output logic        rsp_id
);

  typedef enum logic [2:0] {IDLE, LO, HI, INC, RSP} state_t;

  state_t      state;
  logic [23:0] a_q;
  logic [23:0] b_q;
  logic [23:0] sum_q;
  logic        id_q;
  logic        c_lo;
  logic        c_hi;
  logic        last_grant;

  logic        any_req;
  logic        grant_id;
  logic        accept;
  logic [11:0] op_a;
  logic [11:0] op_b;

  // On a tie, round-robin favours whoever was not granted last.
  always_comb begin
    any_req = req0_valid | req1_valid;
    if (req0_valid && req1_valid)
      grant_id = RR_EN ? ~last_grant : 1'b0;
    else
      grant_id = ~req0_valid;
  end

  // Ready is gated by rst_n so it drops immediately when reset asserts.
  assign accept     = rst_n && (state == IDLE) && any_req;
  assign req0_ready = accept && !grant_id;
  assign req1_ready = accept &&  grant_id;

  always_comb begin
    op_a = 12'h000;
    op_b = 12'h000;
    unique case (state)
      LO: begin
        op_a = a_q[11:0];
        op_b = b_q[11:0];
      end
      HI: begin
        op_a = a_q[23:12];
        op_b = b_q[23:12];
      end
      INC: begin
        op_a = sum_q[23:12];
        op_b = 12'h001;
      end
      default: begin
        op_a = 12'h000;
        op_b = 12'h000;
      end
    endcase
  end

  // The shared adder expects its operands bit-interleaved.
  always_comb begin
    add_in = '0;
    for (int i = 0; i < 12; i++) begin
      add_in[2*i]   = op_a[i];
      add_in[2*i+1] = op_b[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      sum_q      <= '0;
      id_q       <= 1'b0;
      c_lo       <= 1'b0;
      c_hi       <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (any_req) begin
            a_q        <= grant_id ? req1_a : req0_a;
            b_q        <= grant_id ? req1_b : req0_b;
            id_q       <= grant_id;
            last_grant <= grant_id;
            state      <= LO;
          end
        end
        LO: begin
          sum_q[11:0] <= add_out[11:0];
          c_lo        <= add_out[12];
          state       <= HI;
        end
        HI: begin
          sum_q[23:12] <= add_out[11:0];
          c_hi         <= add_out[12];
          state        <= c_lo ? INC : RSP;
        end
        // The low-half carry is folded into the high half here.
        INC: begin
          sum_q[23:12] <= add_out[11:0];
          c_hi         <= c_hi | add_out[12];
          state        <= RSP;
        end
        RSP: begin
          if (rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rsp_valid = (state == RSP);
  assign rsp_sum   = {c_hi, sum_q};
  assign rsp_id    = id_q;

endmodule

// File: tb/tb_adder_share_ctrl.sv
// Scoreboard bench for adder_share_ctrl: a round-robin and a fixed-priority
// instance share stimulus, each driving its own model of the external 12-bit adder.
module tb_adder_share_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic [23:0] req0_a, req0_b, req1_a, req1_b;
  logic        rsp_ready;

  logic        req0_ready, req1_ready, rsp_valid, rsp_id;
  logic [23:0] add_in;
  logic [12:0] add_out;
  logic [24:0] rsp_sum;

  logic        fp_req0_ready, fp_req1_ready, fp_rsp_valid, fp_rsp_id;
  logic [23:0] fp_add_in;
  logic [12:0] fp_add_out;
  logic [24:0] fp_rsp_sum;

  typedef struct packed {
    logic        id;
    logic [24:0] sum;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;
  int   cycle = 0;
  int   acc_cycle = 0;
  int   hs_cycle = 0;
  int   n_acc = 0;
  int   n_rsp = 0;
  logic model_last = 1'b1;
  logic pred;
  bit   busy = 1'b0;
  bit   record_order = 1'b0;
  int   rr_order[$];
  int   fp_order[$];

  // Behaviour of the external adder: de-interleave and add two 12-bit halves.
  function automatic logic [12:0] adder_model(input logic [23:0] x);
    logic [11:0] ta, tb;
    for (int i = 0; i < 12; i++) begin
      ta[i] = x[2*i];
      tb[i] = x[2*i+1];
    end
    return {1'b0, ta} + {1'b0, tb};
  endfunction

  assign add_out    = adder_model(add_in);
  assign fp_add_out = adder_model(fp_add_in);

  adder_share_ctrl #(.RR_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .add_in(add_in), .add_out(add_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_sum(rsp_sum), .rsp_id(rsp_id)
  );

  adder_share_ctrl #(.RR_EN(1'b0)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(fp_req0_ready), .req1_ready(fp_req1_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .add_in(fp_add_in), .add_out(fp_add_out),
    .rsp_valid(fp_rsp_valid), .rsp_ready(rsp_ready),
    .rsp_sum(fp_rsp_sum), .rsp_id(fp_rsp_id)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cycle++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Monitor: predicts each grant from its own arbitration model, pushes the
  // expected response on accept and pops it on the response handshake.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      sb.delete();
      model_last = 1'b1;
      busy = 1'b0;
    end else begin
      if (req0_ready || req1_ready) begin
        if (req0_valid && req1_valid) pred = (model_last == 1'b1) ? 1'b0 : 1'b1;
        else pred = req1_valid;
        checkOutput("ready_while_busy", 32'(busy), 32'd0);
        checkOutput("grant", 32'({req1_ready, req0_ready}), pred ? 32'd2 : 32'd1);
        e.id  = pred;
        e.sum = pred ? ({1'b0, req1_a} + {1'b0, req1_b}) : ({1'b0, req0_a} + {1'b0, req0_b});
        sb.push_back(e);
        model_last = pred;
        busy = 1'b1;
        acc_cycle = cycle;
        n_acc++;
        if (record_order) rr_order.push_back(req1_ready ? 1 : 0);
      end
      if (record_order && (fp_req0_ready || fp_req1_ready))
        fp_order.push_back(fp_req1_ready ? 1 : 0);
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          checkOutput("spurious_rsp", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          checkOutput("rsp_sum", 32'(rsp_sum), 32'(e.sum));
          checkOutput("rsp_id", 32'(rsp_id), 32'(e.id));
        end
        busy = 1'b0;
        hs_cycle = cycle;
        n_rsp++;
      end
    end
  end

  task automatic waitReady(input bit id, input string tag);
    int n = 0;
    @(negedge clk); #1;
    while (!(id ? req1_ready : req0_ready) && n < 30) begin
      @(negedge clk); #1;
      n++;
    end
    checkOutput(tag, 32'(n < 30), 32'd1);
  endtask

  task automatic waitRsp(input string tag);
    int n = 0;
    @(negedge clk); #1;
    while (!rsp_valid && n < 30) begin
      @(negedge clk); #1;
      n++;
    end
    checkOutput(tag, 32'(n < 30), 32'd1);
  endtask

  task automatic applyStimulus(input bit id, input logic [23:0] a, input logic [23:0] b,
                               input int exp_lat, input logic [24:0] exp_sum);
    int t_acc;
    @(posedge clk); #1;
    if (id) begin req1_valid = 1'b1; req1_a = a; req1_b = b; end
    else    begin req0_valid = 1'b1; req0_a = a; req0_b = b; end
    waitReady(id, "accept_timeout");
    t_acc = cycle;
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    waitRsp("rsp_timeout");
    checkOutput("latency", 32'(cycle - t_acc), 32'(exp_lat));
    checkOutput("dir_sum", 32'(rsp_sum), 32'(exp_sum));
    checkOutput("dir_id", 32'(rsp_id), 32'(id));
    @(posedge clk); #1;
  endtask

  task automatic resetPulse();
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  function automatic logic [23:0] randOp();
    logic [23:0] v;
    case ($urandom_range(0, 3))
      0:       v = 24'hFFFFFF;
      1:       v = 24'h000FFF;
      default: v = 24'($urandom);
    endcase
    return v;
  endfunction

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    rsp_ready = 1'b1;
    #2 rst_n = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #2;
    checkOutput("rst_ready", 32'({req1_ready, req0_ready}), 32'd0);
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst_rsp_sum", 32'(rsp_sum), 32'd0);
    checkOutput("rst_rsp_id", 32'(rsp_id), 32'd0);
    checkOutput("rst_add_in", 32'(add_in), 32'd0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    // Directed carry-path scenarios.
    applyStimulus(1'b0, 24'h000FFF, 24'h000001, 4, 25'h0001000);
    applyStimulus(1'b1, 24'hFFFFFF, 24'h000001, 4, 25'h1000000);
    applyStimulus(1'b0, 24'h800000, 24'h800000, 3, 25'h1000000);

    // Grant order with both requesters permanently valid.
    resetPulse();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    req0_a = 24'h000100; req0_b = 24'h000200;
    req1_a = 24'h000300; req1_b = 24'h000400;
    rr_order.delete();
    fp_order.delete();
    record_order = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int n = 0; n < 100 && (rr_order.size() < 4 || fp_order.size() < 4); n++) begin
      @(negedge clk); #1;
    end
    record_order = 1'b0;
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    checkOutput("rr_count", 32'(rr_order.size() >= 4), 32'd1);
    checkOutput("fp_count", 32'(fp_order.size() >= 4), 32'd1);
    for (int i = 0; i < 4 && i < rr_order.size(); i++)
      checkOutput($sformatf("rr_order%0d", i), 32'(rr_order[i]), 32'(i % 2));
    for (int i = 0; i < 4 && i < fp_order.size(); i++)
      checkOutput($sformatf("fp_order%0d", i), 32'(fp_order[i]), 32'd0);
    repeat (10) @(posedge clk);
    #1;

    // Back-pressure: hold the response for five cycles.
    rsp_ready = 1'b0;
    req0_a = 24'h123456; req0_b = 24'h111111; req0_valid = 1'b1;
    waitReady(1'b0, "stall_accept_timeout");
    @(posedge clk); #1;
    req0_valid = 1'b0;
    waitRsp("stall_rsp_timeout");
    req1_a = 24'h000010; req1_b = 24'h000020; req1_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checkOutput("stall_valid", 32'(rsp_valid), 32'd1);
      checkOutput("stall_sum", 32'(rsp_sum), 32'h0234567);
      checkOutput("stall_id", 32'(rsp_id), 32'd0);
      checkOutput("stall_ready", 32'({req1_ready, req0_ready}), 32'd0);
      @(negedge clk); #1;
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    waitReady(1'b1, "post_hs_accept_timeout");
    checkOutput("accept_after_hs", 32'(acc_cycle - hs_cycle), 32'd1);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;

    // Reset asserted while the block is in HI.
    req0_a = 24'h0ABCDE; req0_b = 24'h012345; req0_valid = 1'b1;
    waitReady(1'b0, "hi_accept_timeout");
    @(posedge clk); #1;
    req0_valid = 1'b0;
    @(posedge clk); #1;
    checkOutput("hi_add_in_busy", 32'(add_in != 24'd0), 32'd1);
    req0_valid = 1'b1; req1_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_ready", 32'({req1_ready, req0_ready}), 32'd0);
    checkOutput("mid_rst_valid", 32'(rsp_valid), 32'd0);
    checkOutput("mid_rst_sum", 32'(rsp_sum), 32'd0);
    checkOutput("mid_rst_id", 32'(rsp_id), 32'd0);
    checkOutput("mid_rst_add_in", 32'(add_in), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk); #1;
    checkOutput("post_rst_grant", 32'({req1_ready, req0_ready}), 32'd1);
    checkOutput("post_rst_no_rsp", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    checkOutput("post_rst_drain", 32'(sb.size()), 32'd0);

    // Random traffic against the scoreboard.
    n_acc = 0;
    n_rsp = 0;
    for (int k = 0; k < 400; k++) begin
      @(posedge clk); #1;
      req0_valid = 1'($urandom_range(0, 1));
      req1_valid = 1'($urandom_range(0, 1));
      req0_a = randOp(); req0_b = randOp();
      req1_a = randOp(); req1_b = randOp();
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp_ready = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    checkOutput("rand_sb_empty", 32'(sb.size()), 32'd0);
    checkOutput("rand_acc_eq_rsp", 32'(n_acc), 32'(n_rsp));
    checkOutput("rand_activity", 32'(n_acc > 20), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
